// File: rtl/phy_rx_deframer.sv
// Nibble-to-byte receive deframer: reassembles low-nibble-first bytes from the PHY
// and reports each frame's byte count as good or bad once phy_rx_dv drops.
module phy_rx_deframer #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 2048
) (
  input  logic        clk_phy,
  input  logic        reset_n,
  input  logic [3:0]  phy_data_in,
  input  logic        phy_rx_dv,
  output logic [7:0]  r_data_out,
  output logic        r_data_valid,
  output logic        r_sof,
  output logic [23:0] r_ctrl_out,
  output logic        r_frame_valid,
  output logic        r_frame_err
);

  localparam logic [11:0] MIN_L   = 12'(MIN_LEN);
  localparam logic [11:0] MAX_L   = 12'(MAX_LEN);
  localparam logic [11:0] CNT_SAT = 12'hFFF;

  typedef enum logic [1:0] {IDLE, LO, HI, END} state_t;

  state_t      state, state_nxt;
  logic [1:0]  rst_sync;
  logic        rst_n_int;
  logic        dv_blocked;
  logic [3:0]  low_nib;
  logic [11:0] byte_cnt;
  logic        start, byte_done, frame_end, frame_good;

  // Reset asserts immediately but releases only on a clk_phy edge.
  always_ff @(posedge clk_phy or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n_int = rst_sync[1];

  always_ff @(posedge clk_phy or negedge rst_n_int) begin
    if (!rst_n_int) state <= IDLE;
    else            state <= state_nxt;
  end

  // LO means "expecting a low nibble"; the nibble that opens a frame is already the
  // low half of byte 0, so IDLE moves straight on to expecting its high half.
  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    byte_done  = 1'b0;
    frame_end  = 1'b0;
    frame_good = (state == LO) && (byte_cnt >= MIN_L) && (byte_cnt <= MAX_L) &&
                 (byte_cnt != CNT_SAT);
    case (state)
      IDLE: begin
        if (phy_rx_dv && !dv_blocked) begin
          start     = 1'b1;
          state_nxt = HI;
        end
      end
      LO: begin
        if (phy_rx_dv) begin
          state_nxt = HI;
        end else begin
          frame_end = 1'b1;
          state_nxt = END;
        end
      end
      HI: begin
        if (phy_rx_dv) begin
          byte_done = 1'b1;
          state_nxt = LO;
        end else begin
          frame_end = 1'b1;
          state_nxt = END;
        end
      end
      END:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // dv_blocked stops a frame that was already in flight at reset release from being
  // picked up halfway through; it clears the first time dv is seen low.
  always_ff @(posedge clk_phy or negedge rst_n_int) begin
    if (!rst_n_int) begin
      r_data_out    <= 8'h00;
      r_data_valid  <= 1'b0;
      r_sof         <= 1'b0;
      r_ctrl_out    <= 24'h000000;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      dv_blocked    <= 1'b1;
      low_nib       <= 4'h0;
      byte_cnt      <= 12'h000;
    end else begin
      r_data_valid  <= 1'b0;
      r_sof         <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      if (!phy_rx_dv) dv_blocked <= 1'b0;
      if (start) begin
        low_nib  <= phy_data_in;
        byte_cnt <= 12'h000;
      end
      if ((state == LO) && phy_rx_dv) low_nib <= phy_data_in;
      if (byte_done) begin
        r_data_out   <= {phy_data_in, low_nib};
        r_data_valid <= 1'b1;
        r_sof        <= (byte_cnt == 12'h000);
        if (byte_cnt != CNT_SAT) byte_cnt <= byte_cnt + 12'd1;
      end
      if (frame_end) begin
        if (frame_good) begin
          r_frame_valid <= 1'b1;
          r_ctrl_out    <= {byte_cnt, byte_cnt};
        end else begin
          r_frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_phy_rx_deframer.sv
// Self-checking bench for phy_rx_deframer: directed and random frames compared
// against expectations derived from nibble lists and the frame length rules.
module tb_phy_rx_deframer;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 2048;

  logic        clk_phy;
  logic        reset_n;
  logic [3:0]  phy_data_in;
  logic        phy_rx_dv;
  logic [7:0]  r_data_out;
  logic        r_data_valid;
  logic        r_sof;
  logic [23:0] r_ctrl_out;
  logic        r_frame_valid;
  logic        r_frame_err;

  int          checks;
  int          errors;
  logic [23:0] exp_ctrl;
  logic [3:0]  nib_q[$];

  phy_rx_deframer #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .clk_phy       (clk_phy),
    .reset_n       (reset_n),
    .phy_data_in   (phy_data_in),
    .phy_rx_dv     (phy_rx_dv),
    .r_data_out    (r_data_out),
    .r_data_valid  (r_data_valid),
    .r_sof         (r_sof),
    .r_ctrl_out    (r_ctrl_out),
    .r_frame_valid (r_frame_valid),
    .r_frame_err   (r_frame_err)
  );

  initial clk_phy = 1'b0;
  always #5 clk_phy = ~clk_phy;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One nibble slot: drive on the falling edge, then sample just after the rising edge.
  task automatic applyStimulus(input logic dv, input logic [3:0] nib);
    @(negedge clk_phy);
    phy_rx_dv   = dv;
    phy_data_in = nib;
    @(posedge clk_phy);
    #1;
  endtask

  task automatic fill_random(input int n);
    nib_q.delete();
    for (int i = 0; i < n; i++) nib_q.push_back(4'($urandom));
  endtask

  task automatic check_quiet(input string tag);
    checkOutput(tag, 32'({r_data_valid, r_frame_valid, r_frame_err}), 32'd0);
  endtask

  // Plays nib_q as one frame and checks every byte plus the end-of-frame verdict.
  task automatic send_frame(input int gap_cycles);
    int   n;
    int   nbytes;
    logic good;
    n      = nib_q.size();
    nbytes = n / 2;
    good   = (n % 2 == 0) && (nbytes >= MIN_LEN) && (nbytes <= MAX_LEN) && (nbytes < 4095);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, nib_q[i]);
      if (i % 2 == 1) begin
        checkOutput("byte_valid", 32'(r_data_valid), 32'd1);
        checkOutput("byte_data", 32'({nib_q[i], nib_q[i-1]}), 32'(r_data_out));
        checkOutput("byte_sof", 32'(r_sof), 32'(i == 1));
      end else begin
        checkOutput("no_strobe_low_nibble", 32'(r_data_valid), 32'd0);
      end
    end
    applyStimulus(1'b0, 4'($urandom));
    if (good) exp_ctrl = {12'(nbytes), 12'(nbytes)};
    checkOutput("no_partial_byte", 32'(r_data_valid), 32'd0);
    checkOutput("frame_valid", 32'(r_frame_valid), 32'(good));
    checkOutput("frame_err", 32'(r_frame_err), 32'(!good));
    checkOutput("ctrl_out", 32'(r_ctrl_out), 32'(exp_ctrl));
    applyStimulus(1'b0, 4'($urandom));
    check_quiet("strobe_one_cycle");
    for (int g = 0; g < gap_cycles; g++) begin
      applyStimulus(1'b0, 4'($urandom));
      check_quiet("gap_quiet");
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    exp_ctrl    = 24'h0;
    reset_n     = 1'b1;
    phy_rx_dv   = 1'b1;
    phy_data_in = 4'h3;
    $display("[TB] phy_rx_deframer bench starting");
    #1 reset_n = 1'b0;
    #2;
    checkOutput("rst_data_out", 32'(r_data_out), 32'd0);
    checkOutput("rst_strobes", 32'({r_data_valid, r_sof, r_frame_valid, r_frame_err}), 32'd0);
    checkOutput("rst_ctrl_out", 32'(r_ctrl_out), 32'd0);

    // dv held high across reset release must be ignored until it drops and rises.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'($urandom));
    @(negedge clk_phy);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 4'($urandom));
      check_quiet("dv_across_reset");
    end
    applyStimulus(1'b0, 4'h0);
    check_quiet("dv_dropped");
    applyStimulus(1'b0, 4'h0);

    // 512 bytes of 0xA5, low nibble first.
    nib_q.delete();
    for (int i = 0; i < 512; i++) begin
      nib_q.push_back(4'h5);
      nib_q.push_back(4'hA);
    end
    send_frame(0);
    checkOutput("a5_ctrl", 32'(r_ctrl_out), 32'h200200);

    // Minimum-length frame, shortest gap, then a 512-byte frame.
    fill_random(128);
    send_frame(0);
    fill_random(1024);
    send_frame(1);

    // Odd nibble count, short-by-one, one-over-minimum.
    fill_random(127);
    send_frame(0);
    fill_random(126);
    send_frame(0);
    fill_random(130);
    send_frame(0);

    // Maximum length and one byte beyond it.
    fill_random(2 * MAX_LEN);
    send_frame(0);
    fill_random(2 * MAX_LEN + 2);
    send_frame(0);

    for (int k = 0; k < 8; k++) begin
      fill_random(int'($urandom_range(120, 140)));
      send_frame(int'($urandom_range(0, 2)));
    end

    // Reset mid-frame around byte 100 of a 512-byte frame.
    fill_random(1024);
    for (int i = 0; i < 201; i++) applyStimulus(1'b1, nib_q[i]);
    #2 reset_n = 1'b0;
    exp_ctrl = 24'h0;
    #1;
    checkOutput("midrst_data_out", 32'(r_data_out), 32'd0);
    checkOutput("midrst_strobes", 32'({r_data_valid, r_sof, r_frame_valid, r_frame_err}), 32'd0);
    checkOutput("midrst_ctrl_out", 32'(r_ctrl_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'h0);
      check_quiet("in_reset_quiet");
    end
    @(negedge clk_phy);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 4'h0);
      check_quiet("post_reset_quiet");
      checkOutput("post_reset_ctrl", 32'(r_ctrl_out), 32'd0);
    end
    fill_random(128);
    send_frame(0);
    checkOutput("post_reset_frame_ctrl", 32'(r_ctrl_out), 32'h040040);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
